// File: rtl/arb3_pkg.sv
// Shared state codes, state type and default tenure limit for the 3-channel grant controller.
package arb3_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;
  localparam logic [1:0] GRANT2 = 2'b11;

  typedef logic [1:0] arb_state_t;

  localparam int DEF_MAX_HOLD = 15;
  localparam int HOLD_W       = 4;

  function automatic logic [2:0] state_to_gnt(arb_state_t s);
    logic [2:0] g;
    g = 3'b000;
    case (s)
      GRANT0:  g = 3'b001;
      GRANT1:  g = 3'b010;
      GRANT2:  g = 3'b100;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/arb3_hold_timer.sv
// Grant tenure counter: cleared on grant entry, counts granted cycles, flags the last allowed one.
module arb3_hold_timer
  import arb3_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count holds granted-cycle index minus one, so this fires in the MAX_HOLD-th granted cycle.
  assign expire = enable && (cnt_q == HOLD_W'(MAX_HOLD - 1));

endmodule

// File: rtl/arb3_grant_ctrl.sv
// Three-channel grant controller: loads the external next-state code from IDLE, tracks tenure,
// releases on done / request drop / tenure limit, and keeps saturating per-channel grant counts.
module arb3_grant_ctrl
  import arb3_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [1:0]       ns,
  input  logic [2:0]       done,
  output logic [1:0]       q,
  output logic [2:0]       gnt,
  output logic             busy,
  output logic             timeout,
  output logic             err,
  output logic [CNT_W-1:0] gcnt0,
  output logic [CNT_W-1:0] gcnt1,
  output logic [CNT_W-1:0] gcnt2
);

  // Channel k requests by holding req[k]; a grant lasts while req[k] stays high and ends on a
  // one-cycle done[k], a req[k] drop, or the tenure limit. Every output is a register or a
  // decode of the state register, so no input reaches an output combinationally.
  arb_state_t            state_q, state_d;
  logic [2:0]            gnt_q, gnt_d;
  logic                  timeout_q, timeout_d;
  logic                  err_q, err_d;
  logic [2:0][CNT_W-1:0] gcnt_q, gcnt_d;
  logic                  grant_entry;
  logic                  hold_expire;
  logic                  held;
  logic [1:0]            ns_idx;
  logic [1:0]            cur_idx;

  assign held    = (state_q != IDLE);
  assign ns_idx  = ns - 2'd1;
  assign cur_idx = state_q - 2'd1;

  always_comb begin
    state_d     = state_q;
    timeout_d   = 1'b0;
    err_d       = 1'b0;
    grant_entry = 1'b0;
    gcnt_d      = gcnt_q;
    if (!held) begin
      if (ns != IDLE) begin
        if (req[ns_idx]) begin
          state_d     = ns;
          grant_entry = 1'b1;
          if (gcnt_q[ns_idx] != {CNT_W{1'b1}}) begin
            gcnt_d[ns_idx] = gcnt_q[ns_idx] + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      // A real release takes priority over the tenure limit, suppressing the timeout pulse.
      if (done[cur_idx] || !req[cur_idx]) begin
        state_d = IDLE;
      end else if (hold_expire) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
      end
    end
    gnt_d = state_to_gnt(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 3'b000;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      gcnt_q    <= gcnt_d;
    end
  end

  arb3_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_entry),
    .enable (held),
    .expire (hold_expire)
  );

  assign q       = state_q;
  assign gnt     = gnt_q;
  assign busy    = held;
  assign timeout = timeout_q;
  assign err     = err_q;
  assign gcnt0   = gcnt_q[0];
  assign gcnt1   = gcnt_q[1];
  assign gcnt2   = gcnt_q[2];

endmodule

// File: tb/tb_arb3_grant_ctrl.sv
// Bench for arb3_grant_ctrl: directed scenarios then random traffic against a tenure-level model.
module tb_arb3_grant_ctrl;

  localparam int MAX_HOLD = 15;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [1:0] ns;
  logic [2:0] done;

  logic [1:0] q, q_s;
  logic [2:0] gnt, gnt_s;
  logic       busy, busy_s, timeout, timeout_s, err, err_s;
  logic [7:0] gcnt0, gcnt1, gcnt2;
  logic [1:0] gcnt0_s, gcnt1_s, gcnt2_s;

  int tests_run;
  int tests_failed;

  // Model state: owning channel (-1 = none), granted-cycle index, grant totals.
  int m_owner;
  int m_tenure;
  int m_cnt[3];
  int m_timeout;
  int m_err;
  logic [1:0] exp_q[$];
  logic [1:0] prev_q;
  int n;

  arb3_grant_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .ns(ns), .done(done),
    .q(q), .gnt(gnt), .busy(busy), .timeout(timeout), .err(err),
    .gcnt0(gcnt0), .gcnt1(gcnt1), .gcnt2(gcnt2)
  );

  arb3_grant_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .req(req), .ns(ns), .done(done),
    .q(q_s), .gnt(gnt_s), .busy(busy_s), .timeout(timeout_s), .err(err_s),
    .gcnt0(gcnt0_s), .gcnt1(gcnt1_s), .gcnt2(gcnt2_s)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Reference behaviour for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    m_timeout = 0;
    m_err     = 0;
    if (rst) begin
      m_owner  = -1;
      m_tenure = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      exp_q.delete();
    end else if (m_owner < 0) begin
      if (ns != 2'd0) begin
        if (req[ns - 2'd1]) begin
          m_owner  = int'(ns) - 1;
          m_tenure = 1;
          m_cnt[m_owner]++;
          exp_q.push_back(ns);
        end else begin
          m_err = 1;
        end
      end
    end else begin
      if (done[m_owner] || !req[m_owner]) begin
        m_owner = -1;
      end else if (m_tenure == MAX_HOLD) begin
        m_owner   = -1;
        m_timeout = 1;
      end else begin
        m_tenure++;
      end
    end
  endtask

  task automatic compare_all();
    int exp_gnt;
    exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
    check("q", q, m_owner + 1);
    check("gnt", gnt, exp_gnt);
    check("busy", busy, (m_owner >= 0) ? 1 : 0);
    check("timeout", timeout, m_timeout);
    check("err", err, m_err);
    check("gcnt0", gcnt0, sat(m_cnt[0], 255));
    check("gcnt1", gcnt1, sat(m_cnt[1], 255));
    check("gcnt2", gcnt2, sat(m_cnt[2], 255));
    check("q_s", q_s, m_owner + 1);
    check("gcnt0_s", gcnt0_s, sat(m_cnt[0], 3));
    check("gcnt1_s", gcnt1_s, sat(m_cnt[1], 3));
    check("gcnt2_s", gcnt2_s, sat(m_cnt[2], 3));
    // Scoreboard: each DUT grant entry must match the oldest model-predicted grant.
    if (prev_q == 2'd0 && q != 2'd0) begin
      if (exp_q.size() == 0) check("sb_unexpected_grant", q, 0);
      else check("sb_grant", q, exp_q.pop_front());
    end else if (q == 2'd0 && exp_q.size() != 0) begin
      check("sb_missing_grant", q, exp_q.pop_front());
    end
    prev_q = q;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic [2:0] rq, input logic [1:0] n_s, input logic [2:0] d);
    rst  = r;
    req  = rq;
    ns   = n_s;
    done = d;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    m_owner = -1; m_tenure = 0; m_timeout = 0; m_err = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    prev_q = 2'd0;

    // Reset
    drive(1'b1, 3'b111, 2'b01, 3'b111);
    step();
    step();
    check("rst_q", q, 0);
    check("rst_gnt", gnt, 0);

    // Basic grant to channel 1
    drive(1'b0, 3'b010, 2'b10, 3'b000);
    step();
    check("r33_q", q, 2);
    check("r33_gnt", gnt, 3'b010);
    check("r33_busy", busy, 1);
    check("r33_gcnt1", gcnt1, 1);
    drive(1'b0, 3'b000, 2'b00, 3'b000);
    step();

    // GRANT0, done on granted cycle 4, ns=11 offered during release must be ignored
    drive(1'b0, 3'b001, 2'b01, 3'b000);
    step();
    drive(1'b0, 3'b001, 2'b00, 3'b000);
    for (int i = 0; i < 3; i++) step();
    drive(1'b0, 3'b101, 2'b11, 3'b001);
    step();
    check("r34_rel_q", q, 0);
    drive(1'b0, 3'b100, 2'b11, 3'b000);
    step();
    check("r34_g2_q", q, 3);

    // GRANT2 held to the tenure limit
    drive(1'b0, 3'b100, 2'b00, 3'b000);
    n = 1;
    while (q != 2'd0 && n < 40) begin
      step();
      if (q == 2'd3) n++;
    end
    check("r35_len", n, MAX_HOLD);
    check("r35_timeout", timeout, 1);
    check("r35_q", q, 0);
    step();
    check("r35_pulse", timeout, 0);

    // Tenure limit coincident with done
    drive(1'b0, 3'b010, 2'b10, 3'b000);
    step();
    drive(1'b0, 3'b010, 2'b00, 3'b000);
    for (int i = 0; i < MAX_HOLD - 1; i++) step();
    drive(1'b0, 3'b010, 2'b00, 3'b010);
    step();
    check("r36_q", q, 0);
    check("r36_timeout", timeout, 0);

    // Grant to a non-requesting channel, then reset mid-grant
    drive(1'b0, 3'b000, 2'b01, 3'b000);
    step();
    check("r37_err", err, 1);
    check("r37_q", q, 0);
    drive(1'b0, 3'b000, 2'b00, 3'b000);
    step();
    check("r37_err_pulse", err, 0);
    drive(1'b0, 3'b010, 2'b10, 3'b000);
    step();
    drive(1'b0, 3'b010, 2'b00, 3'b000);
    step();
    drive(1'b1, 3'b010, 2'b10, 3'b000);
    step();
    check("r37_rst_q", q, 0);
    check("r37_rst_gnt", gnt, 0);
    check("r37_rst_gcnt1", gcnt1, 0);

    // Counter saturation: five grants on channel 0
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 3'b001, 2'b01, 3'b000);
      step();
      drive(1'b0, 3'b000, 2'b00, 3'b000);
      step();
      step();
    end
    check("r38_gcnt0_s", gcnt0_s, 3);
    check("r38_gcnt0", gcnt0, 5);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] rq;
      logic [2:0] dn;
      for (int b = 0; b < 3; b++) rq[b] = ($urandom_range(0, 99) < 92);
      dn = ($urandom_range(0, 99) < 6) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      drive(($urandom_range(0, 299) == 0), rq, 2'($urandom_range(0, 3)), dn);
      step();
    end

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arb3_grant_ctrl.md
ARB3_GRANT_CTRL -- requirements
Module: arb3_grant_ctrl

Interface
REQ-001 Parameter MAX_HOLD, default 15, meaning maximum grant tenure in cycles (legal range 2..15).
REQ-002 Parameter CNT_W, default 8, meaning width of each per-channel grant statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  3  request lines from channels 2..0; also routed to the arbiter next-state stage.
REQ-006 ns  input  2  next-state code from the arbiter next-state stage.
REQ-007 done  input  3  per-channel release strobe, one cycle, valid only for the granted channel.
REQ-008 q  output  2  registered state code, fed back to the next-state stage.
REQ-009 gnt  output  3  registered one-hot grant, channels 2..0.
REQ-010 busy  output  1  high whenever any grant is held.
REQ-011 timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD.
REQ-012 err  output  1  one-cycle pulse when ns requests a grant to a non-requesting channel.
REQ-013 gcnt0, gcnt1, gcnt2  output  CNT_W each  saturating count of grants issued per channel.

Function
REQ-014 State codes SHALL be: 00 IDLE, 01 GRANT0, 10 GRANT1, 11 GRANT2.
REQ-015 In IDLE, ns SHALL be sampled each cycle; if ns != 00 and req[k] for the coded channel k is high, q SHALL load ns at the next edge.
REQ-016 In IDLE, ns != 00 with req[k] low SHALL keep q = 00 and pulse err for one cycle.
REQ-017 While q != 00, ns SHALL be ignored.
REQ-018 gnt SHALL be updated on the same edge as q and SHALL equal the one-hot decode of the new q; gnt = 000 in IDLE.
REQ-019 Latency: req[k] high at edge n with ns coding k -> q and gnt[k] valid after edge n+1.
REQ-020 busy SHALL equal (q != 00).
REQ-021 Release: in GRANTk, done[k] high or req[k] low SHALL return q to 00 at the next edge.
REQ-022 Hold counter SHALL clear on grant entry and increment once per granted cycle; when it reaches MAX_HOLD-1 without release, q SHALL return to 00 and timeout SHALL pulse on that same edge.
REQ-023 Simultaneous done[k] (or req[k] drop) and hold expiry: release SHALL occur, timeout SHALL NOT pulse.
REQ-024 done[j] for j != k, or done in IDLE, SHALL be ignored.
REQ-025 After any release, q SHALL spend at least one cycle in IDLE before a new grant (no grant-to-grant transition).
REQ-026 gcntk SHALL increment on each entry to GRANTk and SHALL saturate at 2^CNT_W-1 without wrap.

Reset
REQ-027 On rst high at an edge: q = 00, gnt = 000, busy = 0, timeout = 0, err = 0, hold counter = 0, gcnt0..2 = 0.
REQ-028 rst SHALL override all other inputs, including mid-grant; no timeout or err pulse is generated by reset.
REQ-029 First grant after reset deassertion SHALL follow REQ-015 with no extra delay.

Structure
REQ-030 Shared package arb3_pkg SHALL hold state-code constants (IDLE, GRANT0..2), the state typedef, and the default MAX_HOLD.
REQ-031 Hold counter and expiry compare SHALL be one sub-module, arb3_hold_timer (inputs clear, enable; output expire).
REQ-032 The block SHALL contain no combinational path from req, ns or done to any output.

Verification
REQ-033 rst released, req = 010, ns = 10 -> after one edge q = 10, gnt = 010, busy = 1, gcnt1 = 1.
REQ-034 GRANT0 held, done = 001 on cycle 4 -> q = 00 next edge; next cycle ns = 11 with req[2] = 1 -> q = 11 one edge later, never 01->11 directly.
REQ-035 GRANT2 held, req[2] stays high, no done, MAX_HOLD = 15 -> release on 15th granted cycle, timeout one-cycle pulse, q = 00.
REQ-036 Expiry cycle coincident with done[k] -> q = 00, timeout = 0.
REQ-037 IDLE, req = 000, ns = 01 -> q stays 00, err pulses once; rst asserted mid-GRANT1 -> q = 00, gnt = 000, all gcnt = 0 next edge.
REQ-038 CNT_W = 2, grant channel 0 five times -> gcnt0 = 3 (saturated).
